// File: rtl/aes_final_round_if.sv
// ---------------------------------------------------------------------------
// aes_final_round_if
//   Bus bundle between the round-9 stage of the encryptor and the AES-128
//   final-round block.
//
//   start      : sample state_in/round_key this cycle and compute
//   state_in   : 128-bit state after round 9, flat FIPS-197 byte order
//   round_key  : 128-bit round-10 key (w[40..43]), flat FIPS-197 byte order
//   ciphertext : registered final-round result, flat FIPS-197 byte order
//   done       : one-cycle pulse, ciphertext valid from this cycle on
//
//   master : the side that issues work (encryptor control / testbench)
//   slave  : the final-round block itself
// ---------------------------------------------------------------------------
interface aes_final_round_if;
  logic         start;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic [127:0] ciphertext;
  logic         done;

  modport master (
    output start,
    output state_in,
    output round_key,
    input  ciphertext,
    input  done
  );

  modport slave (
    input  start,
    input  state_in,
    input  round_key,
    output ciphertext,
    output done
  );
endinterface

// File: rtl/aes_final_round.sv
// ---------------------------------------------------------------------------
// aes_final_round
//   AES-128 final round on one 128-bit state: SubBytes -> ShiftRows ->
//   AddRoundKey (no MixColumns). The datapath is purely combinational; the
//   result is captured in one register stage and flagged with a done pulse.
//
//   Ports:
//     clk  : system clock, rising-edge
//     rst  : synchronous, active-high reset (clears ciphertext and done)
//     bus  : aes_final_round_if.slave
//            start/state_in/round_key in, ciphertext/done out
//
//   Byte k of a flat word lives at bits [127-8k -: 8]; matrix element
//   s[r][c] is byte r+4c (column-major), so the flat word is used directly
//   as the matrix without any reordering.
// ---------------------------------------------------------------------------
module aes_final_round (
  input  logic               clk,
  input  logic               rst,
  aes_final_round_if.slave   bus
);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    logic [10:0] msb_idx;
    msb_idx = 11'd2047 - {b, 3'b000};
    return SBOX_TABLE[msb_idx -: 8];
  endfunction

  logic [127:0] s_box;   // after SubBytes
  logic [127:0] s_row;   // after ShiftRows
  logic [127:0] ct_d;    // after AddRoundKey
  logic [127:0] ct_q;
  logic         done_q;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      // Row r rotates left by r: output column c takes input column (c+r) mod 4.
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);

      assign s_box[127 - 8*gi -: 8] = sbox_lookup(bus.state_in[127 - 8*gi -: 8]);
      assign s_row[127 - 8*gi -: 8] = s_box[127 - 8*SRC -: 8];
      assign ct_d [127 - 8*gi -: 8] = s_row[127 - 8*gi -: 8]
                                    ^ bus.round_key[127 - 8*gi -: 8];
    end
  endgenerate

  // Reset wins over start; done follows start so back-to-back starts keep it high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ct_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= bus.start;
      if (bus.start) begin
        ct_q <= ct_d;
      end
    end
  end

  assign bus.ciphertext = ct_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_aes_final_round.sv
// ---------------------------------------------------------------------------
// tb_aes_final_round
//   Directed vectors with hand-computed results for aes_final_round.
//   Inputs change on the falling edge; outputs are sampled 1 time unit after
//   the rising edge.
// ---------------------------------------------------------------------------
module tb_aes_final_round;

  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;

  aes_final_round_if bus ();

  aes_final_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] C1_STATE = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] C1_KEY   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_SBOX  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] C1_SROW  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] ZERO_CT  = 128'h63636363636363636363636363636363;
  localparam logic [127:0] ONES_CT  = 128'h9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c;
  localparam logic [127:0] SR_STATE = 128'h000102030405060708090a0b0c0d0e0f;
  // S-box of bytes 00,05,0a,0f,04,09,0e,03,08,0d,02,07,0c,01,06,0b
  localparam logic [127:0] SR_CT    = 128'h636b6776f201ab7b30d777c5fe7c6f2b;

  task automatic check128(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge.
  task automatic drive(input logic r, input logic s,
                       input logic [127:0] st, input logic [127:0] k);
    @(negedge clk);
    rst           = r;
    bus.start     = s;
    bus.state_in  = st;
    bus.round_key = k;
  endtask

  // Wait for the rising edge and check both outputs.
  task automatic step(input string tag, input logic [127:0] ct_exp,
                      input logic done_exp);
    @(posedge clk);
    #1;
    check128({tag, "_ct"}, bus.ciphertext, ct_exp);
    check1({tag, "_done"}, bus.done, done_exp);
    $display("txn %-12s ciphertext=%h done=%b", tag, bus.ciphertext, bus.done);
  endtask

  initial begin
    assert_count  = 0;
    fail_count    = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.state_in  = '0;
    bus.round_key = '0;

    // Reset state
    drive(1'b1, 1'b0, '0, '0);
    step("reset0", '0, 1'b0);
    drive(1'b1, 1'b1, C1_STATE, C1_KEY);
    step("reset1", '0, 1'b0);

    // FIPS-197 C.1 round 10, plus intermediate probes
    drive(1'b0, 1'b1, C1_STATE, C1_KEY);
    step("c1", C1_CT, 1'b1);
    check128("c1_sbox", dut.s_box, C1_SBOX);
    check128("c1_srow", dut.s_row, C1_SROW);
    drive(1'b0, 1'b0, '0, '1);
    step("c1_hold", C1_CT, 1'b0);

    // Zero state, zero key
    drive(1'b0, 1'b1, '0, '0);
    step("zero", ZERO_CT, 1'b1);
    drive(1'b0, 1'b0, C1_STATE, C1_KEY);
    step("zero_hold", ZERO_CT, 1'b0);

    // Zero state, all-ones key
    drive(1'b0, 1'b1, '0, '1);
    step("ones_key", ONES_CT, 1'b1);

    // ShiftRows permutation check
    drive(1'b0, 1'b1, SR_STATE, '0);
    step("shiftrows", SR_CT, 1'b1);
    drive(1'b0, 1'b0, '0, '0);
    step("sr_hold", SR_CT, 1'b0);

    // Reset priority over start, then idle with random inputs
    drive(1'b0, 1'b1, C1_STATE, C1_KEY);
    step("c1_load", C1_CT, 1'b1);
    drive(1'b1, 1'b1, C1_STATE, C1_KEY);
    step("rst_prio", '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0,
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom});
      step("idle", '0, 1'b0);
    end

    // Back-to-back starts
    drive(1'b0, 1'b1, C1_STATE, C1_KEY);
    step("b2b_0", C1_CT, 1'b1);
    drive(1'b0, 1'b1, '0, '0);
    step("b2b_1", ZERO_CT, 1'b1);
    drive(1'b0, 1'b0, C1_STATE, '1);
    step("b2b_end", ZERO_CT, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
